// File: rtl/muldiv_hilo.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO registers.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU via an ACC state.
module muldiv_hilo #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              annul_i,
  output logic              stallreq_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
`ifdef MULDIV_MADD_EN
  localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;
`endif

  localparam int CW = $clog2(DATA_W);
  localparam int PW = 2 * DATA_W;

`ifdef MULDIV_MADD_EN
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_RUN, S_DIV_END, S_ACC
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_RUN, S_DIV_END
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
`ifdef MULDIV_MADD_EN
  logic              acc_q, acc_d;
  logic              sub_q, sub_d;
`endif

  logic go;
  logic is_mthi, is_mtlo;
  logic is_mult, is_multu;
  logic is_div, is_divu;
  logic mul_req, mul_sgn, acc_req;
  logic div_op, div_zero;

  assign go       = start_i & ~annul_i & (state_q == S_IDLE);
  assign is_mthi  = aluop_i == EXE_MTHI_OP;
  assign is_mtlo  = aluop_i == EXE_MTLO_OP;
  assign is_mult  = aluop_i == EXE_MULT_OP;
  assign is_multu = aluop_i == EXE_MULTU_OP;
  assign is_div   = aluop_i == EXE_DIV_OP;
  assign is_divu  = aluop_i == EXE_DIVU_OP;
  assign div_op   = is_div | is_divu;
  assign div_zero = opb_i == '0;

`ifdef MULDIV_MADD_EN
  logic is_madd, is_maddu, is_msub, is_msubu;
  assign is_madd  = aluop_i == EXE_MADD_OP;
  assign is_maddu = aluop_i == EXE_MADDU_OP;
  assign is_msub  = aluop_i == EXE_MSUB_OP;
  assign is_msubu = aluop_i == EXE_MSUBU_OP;
  assign acc_req  = is_madd | is_maddu
                  | is_msub | is_msubu;
  assign mul_sgn  = is_mult | is_madd | is_msub;
`else
  assign acc_req  = 1'b0;
  assign mul_sgn  = is_mult;
`endif
  assign mul_req  = is_mult | is_multu | acc_req;

  logic [PW-1:0] ext_a, ext_b, product;
  assign ext_a = mul_sgn
               ? {{DATA_W{opa_i[DATA_W-1]}}, opa_i}
               : {{DATA_W{1'b0}}, opa_i};
  assign ext_b = mul_sgn
               ? {{DATA_W{opb_i[DATA_W-1]}}, opb_i}
               : {{DATA_W{1'b0}}, opb_i};
  assign product = ext_a * ext_b;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  assign a_neg = is_div & opa_i[DATA_W-1];
  assign b_neg = is_div & opb_i[DATA_W-1];
  assign a_mag = a_neg ? -opa_i : opa_i;
  assign b_mag = b_neg ? -opb_i : opb_i;

  // Restoring step: shift next dividend bit into the partial remainder.
  logic [DATA_W:0]   shifted, diff;
  logic              fits;
  logic [DATA_W-1:0] quo_fix, rem_fix;
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[DATA_W];
  assign quo_fix = qneg_q ? -quo_q : quo_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;

`ifdef MULDIV_MADD_EN
  logic [PW-1:0] acc_sum;
  assign acc_sum = sub_q ? {hi_q, lo_q} - prod_q
                         : {hi_q, lo_q} + prod_q;
`endif

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    stallreq_o = 1'b0;
`ifdef MULDIV_MADD_EN
    acc_d      = acc_q;
    sub_d      = sub_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          unique case (1'b1)
            is_mthi: hi_d = opa_i;
            is_mtlo: lo_d = opa_i;
            mul_req: begin
              prod_d     = product;
              state_d    = S_MUL;
              stallreq_o = (MUL_LAT == 2) | acc_req;
`ifdef MULDIV_MADD_EN
              acc_d      = acc_req;
              sub_d      = is_msub | is_msubu;
`endif
            end
            div_op & div_zero: begin
              hi_d = opa_i;
              lo_d = '1;
            end
            div_op & ~div_zero: begin
              quo_d      = a_mag;
              dvs_d      = b_mag;
              rem_d      = '0;
              cnt_d      = '0;
              qneg_d     = a_neg ^ b_neg;
              rneg_d     = a_neg;
              state_d    = S_DIV_RUN;
              stallreq_o = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!annul_i) begin
`ifdef MULDIV_MADD_EN
          if (acc_q) begin
            state_d    = S_ACC;
            stallreq_o = 1'b1;
          end else begin
            {hi_d, lo_d} = prod_q;
          end
`else
          {hi_d, lo_d} = prod_q;
`endif
        end
      end
      S_DIV_RUN: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          stallreq_o = 1'b1;
          rem_d = fits ? diff[DATA_W-1:0]
                       : shifted[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], fits};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1))
            state_d = S_DIV_END;
        end
      end
      S_DIV_END: begin
        state_d = S_IDLE;
        if (!annul_i) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
`ifdef MULDIV_MADD_EN
      S_ACC: begin
        state_d = S_IDLE;
        if (!annul_i)
          {hi_d, lo_d} = acc_sum;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`ifdef MULDIV_MADD_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy_o = state_q != S_IDLE;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: vector table plus annul/reset sequences.
// MADD vectors follow MULDIV_MADD_EN.
module tb_muldiv_hilo;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MTHI  = 8'b00010001;
  localparam logic [7:0] OP_MTLO  = 8'b00010011;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_MADD  = 8'b10100110;
  localparam logic [7:0] OP_MSUBU = 8'b10101011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  aluop_i;
  logic [31:0] opa_i, opb_i;
  logic        annul_i;
  logic        stallreq_o, busy_o;
  logic [31:0] hi_o, lo_o;

  muldiv_hilo #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .aluop_i   (aluop_i),
    .opa_i     (opa_i),
    .opb_i     (opb_i),
    .annul_i   (annul_i),
    .stallreq_o(stallreq_o),
    .busy_o    (busy_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op, hold it while stalled, then wait for idle.
  task automatic run(input logic [7:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     output int stalls,
                     output bit to);
    int n;
    start_i = 1'b1;
    aluop_i = op;
    opa_i   = a;
    opb_i   = b;
    stalls  = 0;
    to      = 1'b0;
    #1;
    while (stallreq_o && !to) begin
      stalls++;
      if (stalls > 100) to = 1'b1;
      tick();
      #1;
    end
    tick();
    start_i = 1'b0;
    aluop_i = OP_NOP;
    n = 0;
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
    if (busy_o) to = 1'b1;
  endtask

  initial begin
    int  st;
    bit  to;
    logic [31:0] h0, l0;

    vecs.push_back('{"mthi", OP_MTHI, 32'h12345678, 32'h0,
                     32'h12345678, 32'h0, 0});
    vecs.push_back('{"mtlo", OP_MTLO, 32'h9ABCDEF0, 32'h0,
                     32'h12345678, 32'h9ABCDEF0, 0});
    vecs.push_back('{"mult", OP_MULT, 32'hFFFFFFFF, 32'h2,
                     32'hFFFFFFFF, 32'hFFFFFFFE, 1});
    vecs.push_back('{"multu", OP_MULTU, 32'hFFFFFFFF, 32'h2,
                     32'h1, 32'hFFFFFFFE, 1});
    vecs.push_back('{"mult_big", OP_MULT, 32'hFFFF0000,
                     32'hFFFF0000, 32'h1, 32'h0, 1});
    vecs.push_back('{"div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 33});
    vecs.push_back('{"divu", OP_DIVU, 32'd100, 32'd7,
                     32'd2, 32'd14, 33});
    vecs.push_back('{"divu_z", OP_DIVU, 32'h55, 32'h0,
                     32'h55, 32'hFFFFFFFF, 0});
    vecs.push_back('{"div_ovf", OP_DIV, 32'h80000000,
                     32'hFFFFFFFF, 32'h0, 32'h80000000, 33});
    vecs.push_back('{"div_nb", OP_DIV, 32'd7, 32'hFFFFFFFE,
                     32'h1, 32'hFFFFFFFD, 33});
    vecs.push_back('{"divu_max", OP_DIVU, 32'hFFFFFFFF, 32'h10,
                     32'hF, 32'h0FFFFFFF, 33});
    vecs.push_back('{"unknown", OP_NOP, 32'h5, 32'h6,
                     32'hF, 32'h0FFFFFFF, 0});
    vecs.push_back('{"mthi0", OP_MTHI, 32'h0, 32'h0,
                     32'h0, 32'h0FFFFFFF, 0});
    vecs.push_back('{"mtlo10", OP_MTLO, 32'd10, 32'h0,
                     32'h0, 32'd10, 0});
`ifdef MULDIV_MADD_EN
    vecs.push_back('{"madd", OP_MADD, 32'd3, 32'd4,
                     32'h0, 32'd22, 2});
    vecs.push_back('{"msubu", OP_MSUBU, 32'd30, 32'd1,
                     32'hFFFFFFFF, 32'hFFFFFFF8, 2});
`else
    vecs.push_back('{"madd_off", OP_MADD, 32'd3, 32'd4,
                     32'h0, 32'd10, 0});
    vecs.push_back('{"msubu_off", OP_MSUBU, 32'd30, 32'd1,
                     32'h0, 32'd10, 0});
`endif

    rst = 1'b1; start_i = 1'b0; aluop_i = OP_NOP;
    opa_i = '0; opb_i = '0; annul_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_stall", {31'b0, stallreq_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);

    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, st, to);
      chk({vecs[i].name, "_to"}, {31'b0, to}, 32'h0);
      chk({vecs[i].name, "_stall"}, st, vecs[i].stalls);
      chk({vecs[i].name, "_hi"}, hi_o, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo_o, vecs[i].lo);
    end

    // Annul of a running divide.
    run(OP_MTHI, 32'hAAAA0000, 32'h0, st, to);
    run(OP_MTLO, 32'h0000BBBB, 32'h0, st, to);
    h0 = 32'hAAAA0000;
    l0 = 32'h0000BBBB;
    chk("pre_hi", hi_o, h0);
    chk("pre_lo", lo_o, l0);
    start_i = 1'b1; aluop_i = OP_DIV;
    opa_i = 32'd100; opb_i = 32'd7;
    #1;
    chk("div_s0_stall", {31'b0, stallreq_o}, 32'h1);
    for (int c = 1; c < 10; c++) begin
      tick();
      if (c == 3)
        chk("div_busy", {31'b0, busy_o}, 32'h1);
    end
    tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    chk("annul_stall", {31'b0, stallreq_o}, 32'h0);
    tick();
    annul_i = 1'b0;
    aluop_i = OP_NOP;
    chk("annul_busy", {31'b0, busy_o}, 32'h0);
    chk("annul_hi", hi_o, h0);
    chk("annul_lo", lo_o, l0);
    tick();
    chk("annul_hi2", hi_o, h0);

    // Annul in idle suppresses a start.
    start_i = 1'b1; aluop_i = OP_MTHI;
    opa_i = 32'h1; annul_i = 1'b1;
    #1;
    chk("idle_annul_stall", {31'b0, stallreq_o}, 32'h0);
    tick();
    start_i = 1'b0; annul_i = 1'b0; aluop_i = OP_NOP;
    chk("idle_annul_hi", hi_o, h0);

    // Synchronous reset in the middle of a divide.
    start_i = 1'b1; aluop_i = OP_DIVU;
    opa_i = 32'd100; opb_i = 32'd7;
    for (int c = 0; c < 5; c++) tick();
    start_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_hi", hi_o, 32'h0);
    chk("mrst_lo", lo_o, 32'h0);
    chk("mrst_busy", {31'b0, busy_o}, 32'h0);
    chk("mrst_stall", {31'b0, stallreq_o}, 32'h0);
    tick();
    chk("mrst_hold", {31'b0, busy_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
